// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for clock_period_meter.
//   state_t      : measurement FSM encoding
//   REF_PERIOD   : nominal full periods of the four divider settings, in Clk_in cycles
//   SEL_*        : Sel output codes, index into REF_PERIOD
//   within_tol   : unsigned |p - r| <= tol without wrap-around
package clock_period_meter_pkg;

   typedef enum logic {
      S_ARM  = 1'b0,
      S_MEAS = 1'b1
   } state_t;

   localparam int NUM_CLASS = 4;

   localparam logic [1:0] SEL_780 = 2'd0;
   localparam logic [1:0] SEL_390 = 2'd1;
   localparam logic [1:0] SEL_78  = 2'd2;
   localparam logic [1:0] SEL_38  = 2'd3;

   localparam int unsigned REF_PERIOD [NUM_CLASS] = '{780, 390, 78, 38};

   function automatic logic within_tol(input int unsigned p,
                                       input int unsigned r,
                                       input int unsigned tol);
      int unsigned diff;
      diff = (p >= r) ? (p - r) : (r - p);
      return (diff <= tol);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge strobe.
//   Clk_in   : sampling clock
//   Rst      : synchronous active-high reset, clears all flops
//   Async_in : asynchronous input
//   Rise_stb : one Clk_in-cycle pulse per rising edge of Async_in
module sync_edge_detect (
   input  logic Clk_in,
   input  logic Rst,
   input  logic Async_in,
   output logic Rise_stb
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge Clk_in) begin
      if (Rst) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         prev_q   <= 1'b0;
         Rise_stb <= 1'b0;
      end else begin
         meta_q   <= Async_in;
         sync_q   <= meta_q;
         prev_q   <= sync_q;
         Rise_stb <= sync_q & ~prev_q;
      end
   end

endmodule

// File: rtl/clock_period_meter.sv
// Measures the rising-to-rising period of Sig_in in Clk_in cycles and classifies it
// against the four divider settings (780/390/78/38 cycles).
// Optional build macro: CLOCK_PERIOD_METER_HYST_EN -- Locked needs two consecutive
// measurements of the same class; Sel only moves when that happens.
//   Clk_in  : system clock, posedge
//   Rst     : synchronous active-high reset
//   Sig_in  : asynchronous square wave under test
//   Period  : last measured period
//   Sel     : decoded setting (0=780, 1=390, 2=78, 3=38)
//   Valid   : one-cycle pulse when Period/Sel/Locked update
//   Locked  : last measurement matched a class
//   Timeout : sticky loss-of-signal flag, cleared by the next edge
//
// state  | meaning
// S_ARM  | waiting for a first edge; no measurement in progress
// S_MEAS | counting since the last edge; each edge closes one period
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int CNT_W       = 12,
   parameter int TOL         = 4,
   parameter int TIMEOUT_CYC = 2047
) (
   input  logic             Clk_in,
   input  logic             Rst,
   input  logic             Sig_in,
   output logic [CNT_W-1:0] Period,
   output logic [1:0]       Sel,
   output logic             Valid,
   output logic             Locked,
   output logic             Timeout
);

   localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYC - 1);

   logic             edge_stb;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             hit;
   logic [1:0]       hit_cls;
   logic             tmo_hit;

   sync_edge_detect u_sync (
      .Clk_in   (Clk_in),
      .Rst      (Rst),
      .Async_in (Sig_in),
      .Rise_stb (edge_stb)
   );

   // Saturating increment; also the period value closed by an edge (cnt counts P-1).
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
   assign tmo_hit = (cnt == CNT_TMO);

   // Classes scanned from last to first so the lowest matching index wins.
   always_comb begin
      hit     = 1'b0;
      hit_cls = SEL_780;
      for (int i = NUM_CLASS - 1; i >= 0; i--) begin
         if (within_tol(32'(cnt_inc), REF_PERIOD[i], 32'(TOL))) begin
            hit     = 1'b1;
            hit_cls = 2'(i);
         end
      end
   end

   always_ff @(posedge Clk_in) begin
      if (Rst) state <= S_ARM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ARM:   if (edge_stb) state_nxt = S_MEAS;
         S_MEAS:  if (!edge_stb && tmo_hit) state_nxt = S_ARM;
         default: state_nxt = S_ARM;
      endcase
   end

`ifdef CLOCK_PERIOD_METER_HYST_EN
   logic       cand_vld;
   logic [1:0] cand_cls;
`endif

   always_ff @(posedge Clk_in) begin
      if (Rst) begin
         cnt     <= '0;
         Period  <= '0;
         Sel     <= SEL_780;
         Valid   <= 1'b0;
         Locked  <= 1'b0;
         Timeout <= 1'b0;
`ifdef CLOCK_PERIOD_METER_HYST_EN
         cand_vld <= 1'b0;
         cand_cls <= SEL_780;
`endif
      end else begin
         Valid <= 1'b0;
         case (state)
            S_ARM: begin
               if (edge_stb) begin
                  cnt     <= '0;
                  Timeout <= 1'b0;
               end
            end
            S_MEAS: begin
               if (edge_stb) begin
                  cnt    <= '0;
                  Period <= cnt_inc;
                  Valid  <= 1'b1;
`ifdef CLOCK_PERIOD_METER_HYST_EN
                  if (hit) begin
                     cand_vld <= 1'b1;
                     cand_cls <= hit_cls;
                     if (cand_vld && cand_cls == hit_cls) begin
                        Locked <= 1'b1;
                        Sel    <= hit_cls;
                     end else begin
                        Locked <= 1'b0;
                     end
                  end else begin
                     Locked   <= 1'b0;
                     cand_vld <= 1'b0;
                  end
`else
                  Locked <= hit;
                  if (hit) Sel <= hit_cls;
`endif
               end else if (tmo_hit) begin
                  Timeout <= 1'b1;
                  Locked  <= 1'b0;
`ifdef CLOCK_PERIOD_METER_HYST_EN
                  cand_vld <= 1'b0;
`endif
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

   typedef struct packed {
      logic [11:0] period;
      logic [1:0]  sel;
      logic        locked;
   } exp_t;

   logic        Clk_in = 1'b0;
   logic        Rst    = 1'b1;
   logic        Sig_in = 1'b0;
   logic [11:0] Period;
   logic [1:0]  Sel;
   logic        Valid;
   logic        Locked;
   logic        Timeout;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   clock_period_meter #(.CNT_W(12), .TOL(4), .TIMEOUT_CYC(2047)) dut (
      .Clk_in  (Clk_in),
      .Rst     (Rst),
      .Sig_in  (Sig_in),
      .Period  (Period),
      .Sel     (Sel),
      .Valid   (Valid),
      .Locked  (Locked),
      .Timeout (Timeout)
   );

   always #5 Clk_in = ~Clk_in;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      Sig_in = v;
      repeat (n) @(negedge Clk_in);
   endtask

   // One full period starting with a rising edge; the expected result is queued and
   // appears once the next rising edge closes this period.
   task automatic period(input int p, input int ep, input int es, input int el);
      exp_t e;
      hold(1'b1, p / 2);
      hold(1'b0, p - p / 2);
      e.period = 12'(ep);
      e.sel    = 2'(es);
      e.locked = 1'(el);
      sb_q.push_back(e);
   endtask

   always @(negedge Clk_in) begin
      if (Valid) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got Period=%0d Sel=%0d Locked=%0d, expected no Valid",
                     Period, Sel, Locked);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("meas_period", int'(Period), int'(e.period));
            check("meas_sel",    int'(Sel),    int'(e.sel));
            check("meas_locked", int'(Locked), int'(e.locked));
         end
      end
   end

   initial begin
      Rst    = 1'b1;
      Sig_in = 1'b0;
      repeat (3) @(negedge Clk_in);
      check("rst_period",  int'(Period),  0);
      check("rst_sel",     int'(Sel),     0);
      check("rst_valid",   int'(Valid),   0);
      check("rst_locked",  int'(Locked),  0);
      check("rst_timeout", int'(Timeout), 0);
      Rst = 1'b0;
      hold(1'b0, 10);

`ifndef CLOCK_PERIOD_METER_HYST_EN
      // 780-cycle square wave: first edge only arms
      for (int i = 0; i < 4; i++) period(780, 780, 0, 1);
      // switch to 390 then 38
      for (int i = 0; i < 2; i++) period(390, 390, 1, 1);
      for (int i = 0; i < 3; i++) period(38, 38, 3, 1);
      // 84 is outside 78+/-4: unlocked, Sel holds 3; 82 is on the boundary
      period(84, 84, 3, 0);
      period(82, 82, 2, 1);

      // loss of signal after lock
      hold(1'b1, 20);
      hold(1'b0, 1900);
      check("pre_timeout_flag",   int'(Timeout), 0);
      check("pre_timeout_locked", int'(Locked),  1);
      hold(1'b0, 200);
      check("timeout_flag",   int'(Timeout), 1);
      check("timeout_locked", int'(Locked),  0);
      check("timeout_period", int'(Period),  82);
      check("timeout_sel",    int'(Sel),     2);
      // first edge after timeout re-arms without Valid
      hold(1'b1, 50);
      check("rearm_timeout", int'(Timeout), 0);
      check("rearm_period",  int'(Period),  82);
      hold(1'b0, 28);
      e_push78: begin
         exp_t e;
         e.period = 12'd78;
         e.sel    = 2'd2;
         e.locked = 1'b1;
         sb_q.push_back(e);
      end

      // reset in the middle of a period
      hold(1'b1, 39);
      hold(1'b0, 10);
      Rst = 1'b1;
      @(negedge Clk_in);
      check("midrst_period",  int'(Period),  0);
      check("midrst_sel",     int'(Sel),     0);
      check("midrst_valid",   int'(Valid),   0);
      check("midrst_locked",  int'(Locked),  0);
      check("midrst_timeout", int'(Timeout), 0);
      Rst = 1'b0;
      hold(1'b0, 20);
      for (int i = 0; i < 2; i++) period(390, 390, 1, 1);
`else
      // hysteresis: 390 then 780,780 -> lock only on the second consecutive 780
      period(390, 390, 0, 0);
      period(780, 780, 0, 0);
      period(780, 780, 0, 1);
`endif

      // closing edge for the last queued period
      hold(1'b1, 10);
      hold(1'b0, 10);
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge Clk_in);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
